// File: rtl/pcs_pkg.sv
// Shared PCS character constants, TX scheduler state encoding and encoder payload.
package pcs_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;   // comma / idle
    localparam logic [7:0] K28_1 = 8'h3C;   // start of frame
    localparam logic [7:0] K28_2 = 8'h5C;   // end of frame
    localparam logic [7:0] K28_3 = 8'h7C;   // underrun filler

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DATA  = 2'd2,
        ST_EOF   = 2'd3
    } tx_state_t;

    // One character as presented to the 8b/10b encoder.
    typedef struct packed {
        logic [7:0] data;
        logic       k;
    } enc_char_t;

    // Build a control (K) character.
    function automatic enc_char_t kchar(input logic [7:0] code);
        enc_char_t c;
        c.data = code;
        c.k    = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pcs_tx_scheduler_if.sv
// Upstream byte-stream handshake into the PCS TX scheduler.
interface pcs_tx_scheduler_if;

    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;

    modport master (output s_valid, output s_data, output s_last, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);

endinterface

// File: rtl/pcs_tx_scheduler.sv
// PCS transmit sequencer: comma alignment, idle fill, SOF/EOF framing,
// minimum inter-frame gap and underrun filler insertion.
module pcs_tx_scheduler
    import pcs_pkg::*;
#(
    parameter int unsigned ALIGN_LEN = 16,
    parameter int unsigned IFG_LEN   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                link_en,
    pcs_tx_scheduler_if.slave   up,
    output logic                enc_tx_en,
    output logic [7:0]          enc_data,
    output logic                enc_k,
    output logic                align_done,
    output logic                underrun
);

    localparam int unsigned ALIGN_W = ($clog2(ALIGN_LEN + 1) < 1) ? 1 : $clog2(ALIGN_LEN + 1);
    localparam int unsigned GAP_W   = ($clog2(IFG_LEN + 1) < 1) ? 1 : $clog2(IFG_LEN + 1);

    localparam logic [ALIGN_W-1:0] ALIGN_MAX  = ALIGN_W'(ALIGN_LEN);
    localparam logic [ALIGN_W-1:0] ALIGN_LAST = ALIGN_W'(ALIGN_LEN - 1);
    localparam logic [GAP_W-1:0]   GAP_MAX    = GAP_W'(IFG_LEN);

    tx_state_t          state, state_nxt;
    logic [ALIGN_W-1:0] align_cnt, align_cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
    enc_char_t          char_nxt;
    logic               align_done_nxt;
    logic               underrun_nxt;
    logic               gap_ok;

    // Byte is taken whenever a frame is open and the link is up.
    assign up.s_ready = (state == ST_DATA) && link_en;

    // Gap counter saturates at IFG_LEN, so equality means the gap is satisfied.
    assign gap_ok = (IFG_LEN == 0) || (gap_cnt == GAP_MAX);

    // Next-state, counter and next-character selection.
    always_comb begin
        state_nxt      = state;
        align_cnt_nxt  = align_cnt;
        gap_cnt_nxt    = gap_cnt;
        char_nxt       = kchar(K28_5);
        underrun_nxt   = 1'b0;
        align_done_nxt = (state != ST_ALIGN);

        if (!link_en) begin
            state_nxt      = ST_ALIGN;
            align_cnt_nxt  = '0;
            gap_cnt_nxt    = '0;
            align_done_nxt = 1'b0;
        end else begin
            case (state)
                ST_ALIGN: begin
                    if (align_cnt != ALIGN_MAX) begin
                        align_cnt_nxt = align_cnt + ALIGN_W'(1);
                    end
                    if (align_cnt == ALIGN_LAST) begin
                        state_nxt   = ST_IDLE;
                        gap_cnt_nxt = GAP_MAX;
                    end
                end
                ST_IDLE: begin
                    if (gap_ok && up.s_valid) begin
                        char_nxt  = kchar(K28_1);
                        state_nxt = ST_DATA;
                    end else if (gap_cnt != GAP_MAX) begin
                        gap_cnt_nxt = gap_cnt + GAP_W'(1);
                    end
                end
                ST_DATA: begin
                    if (up.s_valid) begin
                        char_nxt.data = up.s_data;
                        char_nxt.k    = 1'b0;
                        if (up.s_last) begin
                            state_nxt = ST_EOF;
                        end
                    end else begin
                        char_nxt     = kchar(K28_3);
                        underrun_nxt = 1'b1;
                    end
                end
                ST_EOF: begin
                    char_nxt    = kchar(K28_2);
                    gap_cnt_nxt = '0;
                    state_nxt   = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_ALIGN;
                end
            endcase
        end
    end

    // State, counters and registered encoder-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ALIGN;
            align_cnt  <= '0;
            gap_cnt    <= '0;
            enc_tx_en  <= 1'b0;
            enc_data   <= K28_5;
            enc_k      <= 1'b1;
            align_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            align_cnt  <= align_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            enc_tx_en  <= link_en;
            enc_data   <= char_nxt.data;
            enc_k      <= char_nxt.k;
            align_done <= align_done_nxt;
            underrun   <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_pcs_tx_scheduler.sv
// Scoreboard bench for pcs_tx_scheduler: dut0 uses ALIGN_LEN=16/IFG_LEN=2,
// dut1 uses ALIGN_LEN=4/IFG_LEN=0.
module tb_pcs_tx_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic link_en0 = 1'b0;
    logic link_en1 = 1'b0;

    logic       tx_en0, k0, ad0, ur0;
    logic [7:0] data0;
    logic       tx_en1, k1, ad1, ur1;
    logic [7:0] data1;

    pcs_tx_scheduler_if bus0 ();
    pcs_tx_scheduler_if bus1 ();

    pcs_tx_scheduler #(.ALIGN_LEN(16), .IFG_LEN(2)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .link_en    (link_en0),
        .up         (bus0.slave),
        .enc_tx_en  (tx_en0),
        .enc_data   (data0),
        .enc_k      (k0),
        .align_done (ad0),
        .underrun   (ur0)
    );

    pcs_tx_scheduler #(.ALIGN_LEN(4), .IFG_LEN(0)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .link_en    (link_en1),
        .up         (bus1.slave),
        .enc_tx_en  (tx_en1),
        .enc_data   (data1),
        .enc_k      (k1),
        .align_done (ad1),
        .underrun   (ur1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] d;
        logic       k;
        logic       ad;
        logic       ur;
        logic       tx;
        string      nm;
    } exp_t;

    typedef struct {
        int    due;
        int    id;
        logic  rdy;
        string nm;
    } rdy_t;

    exp_t exp_q[$];
    rdy_t rdy_q[$];

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of stimulus and queue the hand-computed responses.
    task automatic step(input int id, input bit r, input bit le, input bit v,
                        input logic [7:0] d, input bit l,
                        input logic [7:0] ed, input bit ek, input bit ead,
                        input bit eur, input bit erdy, input string nm);
        exp_t e;
        rdy_t q;
        @(posedge clk);
        #1;
        rst = r;
        if (id == 0) begin
            link_en0 = le; bus0.s_valid = v; bus0.s_data = d; bus0.s_last = l;
        end else begin
            link_en1 = le; bus1.s_valid = v; bus1.s_data = d; bus1.s_last = l;
        end
        q.due = cyc; q.id = id; q.rdy = erdy; q.nm = nm;
        rdy_q.push_back(q);
        e.due = cyc + 1; e.id = id; e.d = ed; e.k = ek; e.ad = ead;
        e.ur = eur; e.tx = r ? 1'b0 : le; e.nm = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every output presentation against the scoreboard.
    exp_t       me;
    rdy_t       mr;
    logic [7:0] a_d;
    logic       a_k, a_ad, a_ur, a_tx, a_rdy;
    always @(negedge clk) begin
        while (rdy_q.size() != 0 && rdy_q[0].due <= cyc) begin
            mr = rdy_q.pop_front();
            a_rdy = (mr.id == 0) ? bus0.s_ready : bus1.s_ready;
            tests++;
            if (mr.due != cyc || a_rdy !== mr.rdy) begin
                fails++;
                $display("FAIL %s s_ready dut%0d cyc %0d: got %b expected %b",
                         mr.nm, mr.id, cyc, a_rdy, mr.rdy);
            end
        end
        while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            me = exp_q.pop_front();
            a_d  = (me.id == 0) ? data0  : data1;
            a_k  = (me.id == 0) ? k0     : k1;
            a_ad = (me.id == 0) ? ad0    : ad1;
            a_ur = (me.id == 0) ? ur0    : ur1;
            a_tx = (me.id == 0) ? tx_en0 : tx_en1;
            tests++;
            if (me.due != cyc || a_d !== me.d || a_k !== me.k || a_ad !== me.ad ||
                a_ur !== me.ur || a_tx !== me.tx) begin
                fails++;
                $display("FAIL %s dut%0d cyc %0d: got d=%h k=%b ad=%b ur=%b tx=%b expected d=%h k=%b ad=%b ur=%b tx=%b",
                         me.nm, me.id, cyc, a_d, a_k, a_ad, a_ur, a_tx,
                         me.d, me.k, me.ad, me.ur, me.tx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.s_valid = 1'b0; bus0.s_data = 8'h00; bus0.s_last = 1'b0;
        bus1.s_valid = 1'b0; bus1.s_data = 8'h00; bus1.s_last = 1'b0;

        // Reset values
        repeat (2) step(0, 1, 0, 0, 8'h00, 0, 8'hBC, 1, 0, 0, 0, "reset");

        // Alignment: exactly 16 commas before align_done
        repeat (16) step(0, 0, 1, 0, 8'h00, 0, 8'hBC, 1, 0, 0, 0, "align");
        step(0, 0, 1, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 0, "aligned_idle");

        // Three-byte frame
        step(0, 0, 1, 1, 8'h11, 0, 8'h3C, 1, 1, 0, 0, "sof1");
        step(0, 0, 1, 1, 8'h11, 0, 8'h11, 0, 1, 0, 1, "d11");
        step(0, 0, 1, 1, 8'h22, 0, 8'h22, 0, 1, 0, 1, "d22");
        step(0, 0, 1, 1, 8'h33, 1, 8'h33, 0, 1, 0, 1, "d33");
        step(0, 0, 1, 0, 8'h00, 0, 8'h5C, 1, 1, 0, 0, "eof1");

        // Back-to-back: two idles enforced before next SOF
        step(0, 0, 1, 1, 8'hAA, 0, 8'hBC, 1, 1, 0, 0, "ifg1");
        step(0, 0, 1, 1, 8'hAA, 0, 8'hBC, 1, 1, 0, 0, "ifg2");
        step(0, 0, 1, 1, 8'hAA, 0, 8'h3C, 1, 1, 0, 0, "sof2");
        step(0, 0, 1, 1, 8'hAA, 0, 8'hAA, 0, 1, 0, 1, "dAA");

        // Underrun: three fillers, then data resumes
        repeat (3) step(0, 0, 1, 0, 8'h00, 0, 8'h7C, 1, 1, 1, 1, "fill");
        step(0, 0, 1, 1, 8'hBB, 1, 8'hBB, 0, 1, 0, 1, "dBB");
        step(0, 0, 1, 0, 8'h00, 0, 8'h5C, 1, 1, 0, 0, "eof2");
        step(0, 0, 1, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 0, "idle2");

        // Link drop mid-frame, then full realignment before any SOF
        step(0, 0, 1, 1, 8'h01, 0, 8'hBC, 1, 1, 0, 0, "ifg3");
        step(0, 0, 1, 1, 8'h01, 0, 8'h3C, 1, 1, 0, 0, "sof3");
        step(0, 0, 1, 1, 8'h01, 0, 8'h01, 0, 1, 0, 1, "d01");
        step(0, 0, 0, 1, 8'h02, 0, 8'hBC, 1, 0, 0, 0, "link_drop");
        repeat (16) step(0, 0, 1, 1, 8'h02, 0, 8'hBC, 1, 0, 0, 0, "realign");
        step(0, 0, 1, 1, 8'h02, 0, 8'h3C, 1, 1, 0, 0, "sof4");
        step(0, 0, 1, 1, 8'h02, 1, 8'h02, 0, 1, 0, 1, "d02");
        step(0, 0, 1, 0, 8'h00, 0, 8'h5C, 1, 1, 0, 0, "eof4");
        step(0, 0, 1, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 0, "idle4");

        // Reset during DATA: reset values, no EOF, realign from zero
        step(0, 0, 1, 1, 8'h07, 0, 8'hBC, 1, 1, 0, 0, "ifg5");
        step(0, 0, 1, 1, 8'h07, 0, 8'h3C, 1, 1, 0, 0, "sof5");
        step(0, 0, 1, 1, 8'h07, 0, 8'h07, 0, 1, 0, 1, "d07");
        step(0, 1, 1, 1, 8'h08, 0, 8'hBC, 1, 0, 0, 1, "rst_mid");
        repeat (16) step(0, 0, 1, 0, 8'h00, 0, 8'hBC, 1, 0, 0, 0, "realign_rst");
        step(0, 0, 1, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 0, "aligned_rst");

        // IFG_LEN=0 instance: single-byte frames, EOF directly followed by SOF
        repeat (4) step(1, 0, 1, 0, 8'h00, 0, 8'hBC, 1, 0, 0, 0, "d1_align");
        step(1, 0, 1, 1, 8'hA1, 0, 8'h3C, 1, 1, 0, 0, "d1_sof1");
        step(1, 0, 1, 1, 8'hA1, 1, 8'hA1, 0, 1, 0, 1, "d1_a1");
        step(1, 0, 1, 1, 8'hB1, 1, 8'h5C, 1, 1, 0, 0, "d1_eof1");
        step(1, 0, 1, 1, 8'hB1, 1, 8'h3C, 1, 1, 0, 0, "d1_sof2");
        step(1, 0, 1, 1, 8'hB1, 1, 8'hB1, 0, 1, 0, 1, "d1_b1");
        step(1, 0, 1, 0, 8'h00, 0, 8'h5C, 1, 1, 0, 0, "d1_eof2");
        step(1, 0, 1, 0, 8'h00, 0, 8'hBC, 1, 1, 0, 0, "d1_idle");

        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0 || rdy_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d output and %0d ready entries left, expected 0",
                     exp_q.size(), rdy_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pcs_tx_scheduler.md
# pcs_tx_scheduler

Transmit-side sequencer for the PCS link. It sits between the upstream byte-stream source and the 8b/10b encoder (`encoder_8b10b`), and decides every character the encoder emits each cycle. After enable it performs comma alignment, then fills idle time with K28.5. It frames each upstream packet with start and end delimiters, enforces a minimum inter-frame gap, and substitutes a filler K-code on upstream underrun.

## Interface
Parameters:
- `ALIGN_LEN`, default 16: number of K28.5 commas sent after enable before traffic is allowed; must be ≥1.
- `IFG_LEN`, default 2: minimum idle (K28.5) characters between an EOF and the next SOF; 0 is legal.

Ports:
- `clk`, in, 1: single clock domain.
- `rst`, in, 1: reset, synchronous and active-high.
- `link_en`, in, 1: link enable; low means hold and re-align.
- `s_valid`, in, 1: upstream byte valid.
- `s_data`, in, 8: upstream byte.
- `s_last`, in, 1: marks the final byte of a frame.
- `s_ready`, out, 1: byte accepted when `s_valid & s_ready`.
- `enc_tx_en`, out, 1: drives the encoder `tx_en`.
- `enc_data`, out, 8: drives the encoder `data_in`.
- `enc_k`, out, 1: drives the encoder `k_select`.
- `align_done`, out, 1: high while the link is aligned.
- `underrun`, out, 1: one-cycle pulse per filler inserted.

## Operation
- Character set (`enc_data`/`enc_k`):
  - IDLE/COMMA: K28.5 = 0xBC/1.
  - SOF: K28.1 = 0x3C/1.
  - EOF: K28.2 = 0x5C/1.
  - FILL: K28.3 = 0x7C/1.
  - Data: `s_data`/0.
- States: ALIGN, IDLE, DATA, EOF.
- ALIGN:
  - Emits COMMA.
  - `align_cnt` increments each cycle while `link_en` is high.
  - On the cycle emitting comma number `ALIGN_LEN`, go to IDLE, set `align_done`, and preset `gap_cnt = IFG_LEN`.
- IDLE:
  - If `gap_cnt ≥ IFG_LEN` and `s_valid`: emit SOF and go to DATA. No byte is consumed.
  - Otherwise emit COMMA and increment `gap_cnt`, saturating at `IFG_LEN`.
- DATA:
  - `s_ready = 1`.
  - On accept: emit `s_data` with k=0.
  - If `s_last` is also set, go to EOF.
  - If `s_valid` is low: emit FILL, pulse `underrun`, stay in DATA (the frame stays open).
- EOF: emit EOF, clear `gap_cnt` to 0, go to IDLE.
- `s_ready` is combinational: it equals `(state==DATA) & link_en`. It is low in every other state.
- `link_en` low, any state:
  - Next state is ALIGN with `align_cnt` and `gap_cnt` cleared.
  - `align_done` falls to 0.
  - An in-progress frame is abandoned: no EOF is sent and the upstream flush is the upstream's duty.
  - Output character is COMMA.
- Counter widths: `$clog2(ALIGN_LEN+1)` for `align_cnt` and `$clog2(IFG_LEN+1)` for `gap_cnt` (minimum 1 bit). Both saturate and never wrap.

## Timing
- All outputs except `s_ready` are registered.
- Reset values:
  - `enc_tx_en = 0`
  - `enc_data = 0xBC`
  - `enc_k = 1`
  - `align_done = 0`
  - `underrun = 0`
  - state ALIGN, counters 0.
- `enc_tx_en` equals `link_en` delayed one cycle.
- Accepted byte → appears on `enc_data` the next cycle (latency 1). The encoder adds one more cycle, so latency to the 10-bit symbol is 2.
- `underrun` asserts in the same cycle the FILL character is on `enc_data`.
- `align_done` rises in the same cycle the first post-ALIGN character is presented.
- Boundary cases:
  - With `IFG_LEN = 0`, EOF is immediately followed by SOF if `s_valid` is high.
  - A single-byte frame (`s_last` on the first beat) gives SOF, D, EOF.
  - `rst` has priority over `link_en`.
  - `rst` mid-frame returns to reset values with no EOF.

## Structure
- Shared package `pcs_pkg`:
  - K-code constants `K28_5`, `K28_1`, `K28_2`, `K28_3`.
  - `tx_state_t` enum.
  - The receive-side block will import the same constants.
- No sub-module. This block and `encoder_8b10b` are instantiated side by side in the PCS TX top.

## Test plan
1. Reset, then `link_en = 1`, `ALIGN_LEN = 16` → exactly 16 cycles of 0xBC/k=1 with `align_done = 0`, then `align_done = 1` and 0xBC continues.
2. Frame 0x11, 0x22, 0x33 (last) with `s_valid` held → 0x3C/k, 0x11/d, 0x22/d, 0x33/d, 0x5C/k. `s_ready` is high only during the 3 data cycles. Encoder 10-bit output matches golden K28.1 / D… / K28.2.
3. Back-to-back frames, `IFG_LEN = 2` → exactly two 0xBC between 0x5C and the next 0x3C. Repeat with `IFG_LEN = 0` → 0x5C immediately followed by 0x3C.
4. `s_valid` dropped for 3 cycles mid-frame → three 0x7C/k with `underrun` pulsed 3 times, then data resumes with no byte lost or duplicated.
5. `link_en` dropped mid-frame for 1 cycle → `enc_tx_en` 0 next cycle, `align_done = 0`, `s_ready = 0`. On re-enable, 16 commas are sent before any SOF.
6. `rst` asserted during DATA → next cycle all outputs at reset values; after release, realignment starts from count 0.
